// File: rtl/dp_ram_init.sv
// True dual-port RAM with registered reads and a hardware clear sequence after reset.
// Port A wins write-write collisions; cross-port readers always see the pre-edge word.
module dp_ram_init #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    WRITE_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  ready,
  output logic                  collision
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  in_a, in_b;
  logic                  wr_a, wr_b, wr_clash;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  always_comb begin
    in_a     = ({1'b0, addr_a} < DEPTH_W);
    in_b     = ({1'b0, addr_b} < DEPTH_W);
    wr_a     = (state == S_RUN) && en_a && we_a;
    wr_b     = (state == S_RUN) && en_b && we_b;
    wr_clash = wr_a && wr_b && (addr_a == addr_b);
    rd_a     = in_a ? mem[addr_a] : '0;
    rd_b     = in_b ? mem[addr_b] : '0;
  end

  // Storage has no reset; the clear sequence overwrites every word instead.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_addr] <= INIT_VALUE;
    end else begin
      if (wr_a && in_a)
        mem[addr_a] <= din_a;
      if (wr_b && in_b && !wr_clash)
        mem[addr_b] <= din_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_addr <= '0;
      ready     <= 1'b0;
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      collision <= 1'b0;
      dout_a    <= '0;
      dout_b    <= '0;
    end else begin
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      collision <= 1'b0;
      case (state)
        S_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == LAST_ADDR) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (en_a) begin
            valid_a <= 1'b1;
            dout_a  <= (we_a && WRITE_MODE == 1) ? din_a : rd_a;
          end
          if (en_b) begin
            valid_b <= 1'b1;
            dout_b  <= (we_b && WRITE_MODE == 1) ? din_b : rd_b;
          end
          collision <= wr_clash;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/dp_ram_init.md
# dp_ram_init

Parametrised true dual-port synchronous RAM with two independent read/write ports, registered reads, a selectable same-port read-during-write mode and deterministic write-collision arbitration. After every reset the block runs a hardware clear sequence that writes a known value to every location, then raises `ready`. It is the general-purpose storage primitive for the datapath experiments. It replaces the fixed-size, shared-write-enable two-port memory.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_WIDTH`, 4: address width in bits.
- `DEPTH`, 1<<ADDR_WIDTH: number of words; must be ≤ 2^ADDR_WIDTH.
- `WRITE_MODE`, 0: same-port read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new data).
- `INIT_VALUE`, 0: value written to every word by the clear sequence; DATA_WIDTH bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_a` / `en_b`  in  1  port access request.
- `we_a` / `we_b`  in  1  write enable; only meaningful when the matching `en_*` is 1.
- `addr_a` / `addr_b`  in  ADDR_WIDTH  word address.
- `din_a` / `din_b`  in  DATA_WIDTH  write data.
- `dout_a` / `dout_b`  out  DATA_WIDTH  registered read data.
- `valid_a` / `valid_b`  out  1  one-cycle pulse: the access accepted on the previous edge has completed, and `dout_*` is updated.
- `ready`  out  1  high when the clear sequence is done and accesses are accepted.
- `collision`  out  1  one-cycle pulse: a write-write conflict occurred on the previous edge.

## Operation
- The FSM has two states, INIT and RUN, with a clear counter `init_addr` (ADDR_WIDTH bits).
- Asserting `rst_n`=0 does the following asynchronously:
  - state = INIT, `init_addr` = 0;
  - `ready`, `valid_a`, `valid_b` and `collision` = 0;
  - `dout_a` and `dout_b` = 0.
- Memory contents are not reset directly; they are overwritten by the clear sequence.
- INIT:
  - Each cycle, write INIT_VALUE to mem[`init_addr`] and increment `init_addr`.
  - On the edge that writes address DEPTH-1, move to RUN.
  - All port requests in INIT are ignored: no write, no `valid_*`, and `dout_*` holds.
- RUN: `ready`=1. An access on port X is accepted on any edge where `en_X`=1.
  - Read (`we_X`=0): `dout_X` <= mem[`addr_X`]; `valid_X`=1 on the next cycle.
  - Write (`we_X`=1): mem[`addr_X`] <= `din_X`. `valid_X`=1 on the next cycle. `dout_X` <= old word if WRITE_MODE=0, or `din_X` if WRITE_MODE=1.
  - No access (`en_X`=0): `dout_X` holds and `valid_X`=0.
- Cross-port, same address, one port writing and the other reading: the reader always gets the old word, in either mode, and `collision` is not flagged.
- Both ports writing the same address: port A's data is stored and port B's write is dropped.
  - Both `valid_*` still pulse.
  - `collision`=1 for one cycle.
  - Port B's `dout_b` follows WRITE_MODE using the old word, or `din_b` if write-first.
- Both ports reading the same address: both return the stored word, with no collision.
- Out-of-range address (`addr` ≥ DEPTH): writes are dropped, reads return 0, and `valid` still pulses.
- Reset mid-INIT or mid-RUN: the async clear above applies, and the clear sequence restarts from address 0 after release.

## Timing
- Reset release to `ready`=1: the first rising edge after release writes address 0. `ready` goes high after DEPTH edges (at DEPTH=16: after edge 16).
- Read latency: 1 cycle, registered. A request on edge N has data and `valid` visible after edge N, and sampled on edge N+1.
- Throughput: one access per port per cycle, back-to-back, with no bubbles.
- `collision` is registered and aligned with `valid_*` of the offending accesses.

## Test plan
- **Reset/clear:** INIT_VALUE=8'hA5, release `rst_n`.
  - `ready`=0 for 16 edges, then 1.
  - Reads of addresses 0 and 15 return A5.
  - `valid` stays 0 for a request issued during INIT.
- **Basic R/W:** A writes 0x3C to addr 5, then B reads addr 5 one cycle later.
  - `valid_b`=1 and `dout_b`=0x3C one cycle after the read.
- **Read-during-write:** addr 7 holds 0x11; A writes 0x22 to addr 7.
  - WRITE_MODE=0: `dout_a`=0x11.
  - WRITE_MODE=1: `dout_a`=0x22.
  - A simultaneous B read of addr 7 returns 0x11 in both modes.
- **Write collision:** A writes 0x55 and B writes 0xAA, both to addr 3, on the same edge.
  - `collision`=1 for exactly one cycle.
  - A later read of addr 3 returns 0x55.
- **Reset mid-operation:** while streaming writes, pull `rst_n` low between edges.
  - All outputs go to 0 immediately, without waiting for an edge.
  - After release, `ready` re-rises after 16 edges and the previously written location reads INIT_VALUE.
- **Out of range:** DEPTH=12, A writes 0x77 to addr 13, then reads addr 13.
  - `dout_a`=0 with `valid_a`=1.
  - Address 1 (13 mod 12) is unchanged.
